// File: rtl/memory_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port arbiter.
// The arbiter attaches through the slave modport; the caches/memory environment uses master.
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
);
    localparam int BEAT_W = $clog2(BURST_LEN);

    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  dc_req;
    logic                  dc_we;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_wdata;
    logic [BEAT_W-1:0]     dc_beat;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ic_rvalid;
    logic                  dc_rvalid;
    logic                  ic_done;
    logic                  dc_done;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        output dc_beat, rdata, ic_rvalid, dc_rvalid, ic_done, dc_done,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        input  dc_beat, rdata, ic_rvalid, dc_rvalid, ic_done, dc_done,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between icache refills
// and dcache refills/write-backs, sequencing one full line burst per grant.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    memory_port_arbiter_if.slave    bus
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BURST_LEN * 4 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t                state_r;
    logic                  last_gnt_d_r;
    logic [BEAT_W-1:0]     beat_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  we_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  ic_rvalid_r;
    logic                  dc_rvalid_r;
    logic                  ic_done_r;
    logic                  dc_done_r;
    logic [BEAT_W-1:0]     dc_beat_r;
    logic [BEAT_W-1:0]     beat_inc_s;
    logic                  last_beat_s;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~LINE_MASK;
    endfunction

    // Beat addresses are OR-ed into the line-aligned base, so no carry can leave the line.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [BEAT_W-1:0]     beat);
        return base | ADDR_WIDTH'({beat, 2'b00});
    endfunction

    assign beat_inc_s  = beat_r + BEAT_W'(1);
    assign last_beat_s = (beat_r == BEAT_W'(BURST_LEN - 1));

    // Arbitration FSM, burst sequencing and every registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_gnt_d_r <= 1'b1;
            beat_r       <= BEAT_W'(0);
            base_r       <= ADDR_WIDTH'(0);
            we_r         <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= ADDR_WIDTH'(0);
            rdata_r      <= DATA_WIDTH'(0);
            ic_rvalid_r  <= 1'b0;
            dc_rvalid_r  <= 1'b0;
            ic_done_r    <= 1'b0;
            dc_done_r    <= 1'b0;
            dc_beat_r    <= BEAT_W'(0);
        end else begin
            ic_rvalid_r <= 1'b0;
            dc_rvalid_r <= 1'b0;
            ic_done_r   <= 1'b0;
            dc_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    // On a tie the side that did not win last time is granted.
                    if (bus.ic_req && (!bus.dc_req || last_gnt_d_r)) begin
                        state_r      <= BUSY_I;
                        last_gnt_d_r <= 1'b0;
                        beat_r       <= BEAT_W'(0);
                        base_r       <= line_base(bus.ic_addr);
                        mem_addr_r   <= line_base(bus.ic_addr);
                        we_r         <= 1'b0;
                        mem_we_r     <= 1'b0;
                        mem_req_r    <= 1'b1;
                        dc_beat_r    <= BEAT_W'(0);
                    end else if (bus.dc_req) begin
                        state_r      <= BUSY_D;
                        last_gnt_d_r <= 1'b1;
                        beat_r       <= BEAT_W'(0);
                        base_r       <= line_base(bus.dc_addr);
                        mem_addr_r   <= line_base(bus.dc_addr);
                        we_r         <= bus.dc_we;
                        mem_we_r     <= bus.dc_we;
                        mem_req_r    <= 1'b1;
                        dc_beat_r    <= BEAT_W'(0);
                    end else begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_req_r && bus.mem_ack) begin
                        if (!we_r) begin
                            rdata_r     <= bus.mem_rdata;
                            ic_rvalid_r <= (state_r == BUSY_I);
                            dc_rvalid_r <= (state_r == BUSY_D);
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        if (last_beat_s) begin
                            state_r   <= (state_r == BUSY_I) ? DONE_I : DONE_D;
                            ic_done_r <= (state_r == BUSY_I);
                            dc_done_r <= (state_r == BUSY_D);
                            mem_req_r <= 1'b0;
                            mem_we_r  <= 1'b0;
                            beat_r    <= BEAT_W'(0);
                            dc_beat_r <= BEAT_W'(0);
                        end else begin
                            beat_r     <= beat_inc_s;
                            mem_addr_r <= beat_addr(base_r, beat_inc_s);
                            dc_beat_r  <= (state_r == BUSY_D) ? beat_inc_s : BEAT_W'(0);
                        end
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                DONE_I, DONE_D: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    beat_r    <= BEAT_W'(0);
                    dc_beat_r <= BEAT_W'(0);
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = bus.dc_wdata;
    assign bus.rdata     = rdata_r;
    assign bus.ic_rvalid = ic_rvalid_r;
    assign bus.dc_rvalid = dc_rvalid_r;
    assign bus.ic_done   = ic_done_r;
    assign bus.dc_done   = dc_done_r;
    assign bus.dc_beat   = dc_beat_r;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: bursts, write-back, ties, ack stalls,
// reset mid-burst and request drop mid-burst.
module tb_memory_port_arbiter;
    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    memory_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4)) bus ();

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory returns a tag of the beat address; dcache supplies 0xA0 + beat as write data.
    assign bus.mem_rdata = bus.mem_addr | 32'h5A5A_0000;
    assign bus.dc_wdata  = 32'h0000_00A0 + {30'd0, bus.dc_beat};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check_eq({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check_eq({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check_eq({tag, "_rdata"},     bus.rdata,          32'd0);
        check_eq({tag, "_ic_rvalid"}, 32'(bus.ic_rvalid), 32'd0);
        check_eq({tag, "_dc_rvalid"}, 32'(bus.dc_rvalid), 32'd0);
        check_eq({tag, "_ic_done"},   32'(bus.ic_done),   32'd0);
        check_eq({tag, "_dc_done"},   32'(bus.dc_done),   32'd0);
        check_eq({tag, "_dc_beat"},   32'(bus.dc_beat),   32'd0);
    endtask

    logic [6:0]  ack_pat;
    logic [31:0] stall_addr [7];
    logic        stall_rv   [7];
    logic [31:0] stall_rd   [7];

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        rst          = 1'b1;
        bus.ic_req   = 1'b0;
        bus.ic_addr  = 32'd0;
        bus.dc_req   = 1'b0;
        bus.dc_we    = 1'b0;
        bus.dc_addr  = 32'd0;
        bus.mem_ack  = 1'b1;
        ack_pat      = 7'b1011001;
        stall_addr   = '{32'h6000, 32'h6004, 32'h6004, 32'h6004, 32'h6008, 32'h600C, 32'h600C};
        stall_rv     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        stall_rd     = '{32'h0, 32'h5A5A_6000, 32'h5A5A_6000, 32'h5A5A_6000,
                         32'h5A5A_6004, 32'h5A5A_6008, 32'h5A5A_6008};

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Icache refill, ack always high
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ic_mem_req",  32'(bus.mem_req), 32'd1);
            check_eq("ic_mem_we",   32'(bus.mem_we),  32'd0);
            check_eq("ic_mem_addr", bus.mem_addr,     32'h1230 + 32'(4 * i));
            check_eq("ic_rvalid",   32'(bus.ic_rvalid), 32'(i > 0));
            check_eq("ic_done_early", 32'(bus.ic_done), 32'd0);
            if (i > 0) check_eq("ic_rdata", bus.rdata, 32'h5A5A_1230 + 32'(4 * (i - 1)));
        end
        tick();
        check_eq("ic_done",       32'(bus.ic_done),   32'd1);
        check_eq("ic_last_rv",    32'(bus.ic_rvalid), 32'd1);
        check_eq("ic_last_rdata", bus.rdata,          32'h5A5A_123C);
        check_eq("ic_done_req",   32'(bus.mem_req),   32'd0);
        bus.ic_req = 1'b0;
        tick();
        check_eq("ic_idle_done", 32'(bus.ic_done),   32'd0);
        check_eq("ic_idle_rv",   32'(bus.ic_rvalid), 32'd0);
        check_eq("ic_idle_req",  32'(bus.mem_req),   32'd0);

        // Dcache write-back
        bus.dc_req  = 1'b1;
        bus.dc_we   = 1'b1;
        bus.dc_addr = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wb_mem_req",  32'(bus.mem_req),   32'd1);
            check_eq("wb_mem_we",   32'(bus.mem_we),    32'd1);
            check_eq("wb_mem_addr", bus.mem_addr,       32'h2000 + 32'(4 * i));
            check_eq("wb_dc_beat",  32'(bus.dc_beat),   32'(i));
            check_eq("wb_wdata",    bus.mem_wdata,      32'hA0 + 32'(i));
            check_eq("wb_rvalid",   32'(bus.dc_rvalid), 32'd0);
        end
        tick();
        check_eq("wb_done",    32'(bus.dc_done),   32'd1);
        check_eq("wb_rv_done", 32'(bus.dc_rvalid), 32'd0);
        check_eq("wb_req_off", 32'(bus.mem_req),   32'd0);
        check_eq("wb_we_off",  32'(bus.mem_we),    32'd0);
        bus.dc_req = 1'b0;
        tick();
        check_eq("wb_idle_done", 32'(bus.dc_done), 32'd0);

        // Tie right after reset: icache first, then dcache read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_3008;
        bus.dc_req  = 1'b1;
        bus.dc_we   = 1'b0;
        bus.dc_addr = 32'h0000_4000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("tie_i_addr", bus.mem_addr, 32'h3000 + 32'(4 * i));
            check_eq("tie_i_beat", 32'(bus.dc_beat), 32'd0);
        end
        tick();
        check_eq("tie_i_done", 32'(bus.ic_done), 32'd1);
        check_eq("tie_d_wait", 32'(bus.dc_done), 32'd0);
        bus.ic_req = 1'b0;
        tick();
        check_eq("tie_gap_req", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("tie_d_addr", bus.mem_addr,     32'h4000 + 32'(4 * i));
            check_eq("tie_d_beat", 32'(bus.dc_beat), 32'(i));
            check_eq("tie_d_we",   32'(bus.mem_we),  32'd0);
        end
        tick();
        check_eq("tie_d_done",  32'(bus.dc_done),   32'd1);
        check_eq("tie_d_rv",    32'(bus.dc_rvalid), 32'd1);
        check_eq("tie_d_rdata", bus.rdata,          32'h5A5A_400C);
        check_eq("tie_d_icrv",  32'(bus.ic_rvalid), 32'd0);
        bus.dc_req = 1'b0;
        tick();
        // Second tie: last grant was dcache, so icache wins again
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_5010;
        bus.dc_req  = 1'b1;
        bus.dc_we   = 1'b1;
        bus.dc_addr = 32'h0000_9000;
        tick();
        check_eq("tie2_addr", bus.mem_addr,    32'h5010);
        check_eq("tie2_we",   32'(bus.mem_we), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("tie2_done", 32'(bus.ic_done), 32'd1);
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        tick();

        // Ack stalls on an icache refill
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_6000;
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("stall_req",  32'(bus.mem_req),   32'd1);
            check_eq("stall_addr", bus.mem_addr,       stall_addr[k]);
            check_eq("stall_rv",   32'(bus.ic_rvalid), 32'(stall_rv[k]));
            check_eq("stall_done", 32'(bus.ic_done),   32'd0);
            if (k > 0) check_eq("stall_rdata", bus.rdata, stall_rd[k]);
            bus.mem_ack = ack_pat[k];
        end
        tick();
        check_eq("stall_fin_done",  32'(bus.ic_done),   32'd1);
        check_eq("stall_fin_rv",    32'(bus.ic_rvalid), 32'd1);
        check_eq("stall_fin_rdata", bus.rdata,          32'h5A5A_600C);
        bus.ic_req  = 1'b0;
        bus.mem_ack = 1'b1;
        tick();

        // Reset after two beats, then a tie must favour icache again
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_7004;
        tick();
        tick();
        tick();
        check_eq("rst_pre_addr", bus.mem_addr, 32'h7008);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst        = 1'b0;
        bus.ic_req = 1'b0;
        tick();
        check_eq("midrst_no_done", 32'(bus.ic_done), 32'd0);
        check_eq("midrst_idle",    32'(bus.mem_req), 32'd0);
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_7000;
        bus.dc_req  = 1'b1;
        bus.dc_we   = 1'b0;
        bus.dc_addr = 32'h0000_8000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("restart_addr", bus.mem_addr, 32'h7000 + 32'(4 * i));
        end
        tick();
        check_eq("restart_done", 32'(bus.ic_done), 32'd1);
        bus.ic_req = 1'b0;
        tick();

        // Dcache drops its request after beat 1; the burst still completes
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("drop_req",  32'(bus.mem_req),   32'd1);
            check_eq("drop_addr", bus.mem_addr,       32'h8000 + 32'(4 * i));
            check_eq("drop_beat", 32'(bus.dc_beat),   32'(i));
            if (i == 1) bus.dc_req = 1'b0;
        end
        tick();
        check_eq("drop_done",  32'(bus.dc_done),   32'd1);
        check_eq("drop_rv",    32'(bus.dc_rvalid), 32'd1);
        check_eq("drop_rdata", bus.rdata,          32'h5A5A_800C);
        check_eq("drop_off",   32'(bus.mem_req),   32'd0);
        tick();
        check_eq("drop_idle_done", 32'(bus.dc_done), 32'd0);
        check_eq("drop_idle_req",  32'(bus.mem_req), 32'd0);
        tick();
        check_eq("drop_no_regrant", 32'(bus.mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
